dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Load/store unit between the core execute stage and the dmem port of the memory controller.
//  Accepts one load/store per request, issues a word-aligned mem command with byte strobes,
//  then returns sign/zero-extended load data or a store completion on a one-cycle response.
//  Misaligned accesses are rejected locally and never reach memory. One transaction in flight.
// PARAMETERS
//  p_ADDR_BITS  32               byte address width
//  p_DATA_BITS  32               data width; the block supports 32 only
//  p_STRB_BITS  p_DATA_BITS/8    write strobe width
// PORTS
//  clk          in   1     clock
//  rst          in   1     reset, asynchronous, active-low
//  req_valid    in   1     core request valid
//  req_ready    out  1     request accepted when valid&&ready
//  req_cmd      in   1     0=load 1=store
//  req_size     in   2     0=byte 1=half 2=word 3=illegal
//  req_unsigned in   1     load zero-extends when 1
//  req_addr     in   AB    byte address
//  req_wdata    in   DB    store data, LSB-justified
//  rsp_valid    out  1     one-cycle completion pulse
//  rsp_rdata    out  DB    extended load data (0 for store/error)
//  rsp_err      out  1     misaligned or illegal size
//  mem_addr     out  AB    word-aligned address (addr[1:0]=0)
//  mem_cmd      out  1     0=read 1=write
//  mem_size     out  2     copy of req_size
//  mem_valid    out  1     command valid
//  mem_ready    in   1     command accepted
//  mem_r_valid  in   1     read data valid
//  mem_r_ready  out  1     read data accept
//  mem_r_data   in   DB    read word
//  mem_w_valid  out  1     write data valid, asserted together with mem_valid
//  mem_w_ready  in   1     write data accept
//  mem_w_strb   out  SB    byte lanes, bit i = byte addr[1:0]==i
//  mem_w_data   out  DB    store data shifted to lane (wdata << 8*addr[1:0])
// BEHAVIOUR
//  FSM states: IDLE, CMD, RDATA, RESP. Reset (rst=0, any time, mid-transfer included)
//    -> IDLE; every output 0 except req_ready=1; latched request discarded.
//  IDLE: req_ready=1. On req_valid, latch cmd/size/unsigned/addr/wdata.
//    Illegal (size 3, half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err=1.
//    Otherwise -> CMD. No mem_* activity in IDLE.
//  CMD: mem_valid=1; all mem_* outputs hold stable until accepted.
//    Store: mem_w_valid=1; when mem_ready&&mem_w_ready -> RESP. If mem_ready rises
//    before mem_w_ready, mem_valid drops and mem_w_valid stays high until mem_w_ready.
//    Load: mem_r_ready=1; on mem_ready -> RDATA, unless mem_r_valid is also high in the
//    same cycle, in which case data is captured and the state -> RESP directly.
//  RDATA: mem_r_ready=1; mem_valid=0; on mem_r_valid capture -> RESP.
//    Before the command is accepted, mem_r_valid is ignored.
//  RESP: rsp_valid=1 for exactly one cycle -> IDLE. rsp_rdata and rsp_err are registered
//    and held until the next response. req_ready=0 in CMD, RDATA and RESP.
//  Strobes: byte 4'b0001<<a; half 4'b0011<<a; word 4'b1111 (a=addr[1:0]).
//  Load extract: byte=r_data[8a+7:8a]; half=r_data[8a+15:8a]; word as is.
//    Sign-extend from the top bit unless req_unsigned. Word ignores unsigned.
//  Latency with zero-wait memory: accept at T, mem_valid at T+1,
//    store rsp_valid at T+2, load rsp_valid at T+3 (r_valid at T+2).
//  Error path: rsp_valid at T+1, rsp_rdata=0, mem_valid never asserted.
// TESTING
//  1) store byte 0xA5 @0x103 -> mem_addr 0x100, strb 4'b1000, w_data 0xA5000000, rsp_err 0
//  2) word 0x80FF7F01 @0x100; load byte @0x102 signed -> 0xFFFFFFFF; unsigned -> 0x000000FF
//  3) same word, load half @0x102 signed -> 0xFFFF80FF; load word @0x100 -> 0x80FF7F01
//  4) load word @0x102 -> rsp_valid+rsp_err at T+1, rsp_rdata 0, mem_valid stays 0
//  5) mem_ready low 3 cycles on store half @0x104 -> mem_addr/strb 4'b0011/data stable, single write
//  6) rst=0 while in RDATA -> IDLE, rsp_valid 0, req_ready 1; next load completes normally

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit bridging the execute stage to the dmem port.
// Revision 1.0
`default_nettype none

module dmem_lsu #(
   parameter int p_ADDR_BITS = 32,
   parameter int p_DATA_BITS = 32,
   parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_cmd,
   input  logic [1:0]             req_size,
   input  logic                   req_unsigned,
   input  logic [p_ADDR_BITS-1:0] req_addr,
   input  logic [p_DATA_BITS-1:0] req_wdata,
   output logic                   rsp_valid,
   output logic [p_DATA_BITS-1:0] rsp_rdata,
   output logic                   rsp_err,
   output logic [p_ADDR_BITS-1:0] mem_addr,
   output logic                   mem_cmd,
   output logic [1:0]             mem_size,
   output logic                   mem_valid,
   input  logic                   mem_ready,
   input  logic                   mem_r_valid,
   output logic                   mem_r_ready,
   input  logic [p_DATA_BITS-1:0] mem_r_data,
   output logic                   mem_w_valid,
   input  logic                   mem_w_ready,
   output logic [p_STRB_BITS-1:0] mem_w_strb,
   output logic [p_DATA_BITS-1:0] mem_w_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CMD   = 2'd1;
   localparam logic [1:0] ST_RDATA = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]             r_state;
   logic                   r_cmd;
   logic [1:0]             r_size;
   logic                   r_uns;
   logic [p_ADDR_BITS-1:0] r_addr;
   logic [p_DATA_BITS-1:0] r_wdata;
   logic                   r_cmd_acc;
   logic                   r_w_acc;
   logic [p_DATA_BITS-1:0] r_rsp_rdata;
   logic                   r_rsp_err;

   logic                   w_req_illegal;
   logic [4:0]             w_shamt;
   logic [p_DATA_BITS-1:0] w_rshift;
   logic [p_DATA_BITS-1:0] w_load_ext;
   logic [p_STRB_BITS-1:0] w_strb;
   logic                   w_cmd_hs;
   logic                   w_wr_hs;
   logic                   w_store_done;

   assign w_req_illegal = (req_size == 2'd3) ||
                          ((req_size == 2'd1) && req_addr[0]) ||
                          ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

   assign w_shamt  = {r_addr[1:0], 3'b000};
   assign w_rshift = mem_r_data >> w_shamt;

   always_comb begin
      w_load_ext = w_rshift;
      case (r_size)
         2'd0:    w_load_ext = {{(p_DATA_BITS-8){~r_uns & w_rshift[7]}}, w_rshift[7:0]};
         2'd1:    w_load_ext = {{(p_DATA_BITS-16){~r_uns & w_rshift[15]}}, w_rshift[15:0]};
         default: w_load_ext = w_rshift;
      endcase
   end

   always_comb begin
      w_strb = '1;
      case (r_size)
         2'd0:    w_strb = {{(p_STRB_BITS-1){1'b0}}, 1'b1} << r_addr[1:0];
         2'd1:    w_strb = {{(p_STRB_BITS-2){1'b0}}, 2'b11} << r_addr[1:0];
         default: w_strb = '1;
      endcase
   end

   assign req_ready   = (r_state == ST_IDLE);
   assign rsp_valid   = (r_state == ST_RESP);
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign mem_addr    = {r_addr[p_ADDR_BITS-1:2], 2'b00};
   assign mem_cmd     = r_cmd;
   assign mem_size    = r_size;
   assign mem_valid   = (r_state == ST_CMD) && !r_cmd_acc;
   assign mem_w_valid = (r_state == ST_CMD) && r_cmd && !r_w_acc;
   assign mem_r_ready = !r_cmd && ((r_state == ST_CMD) || (r_state == ST_RDATA));
   assign mem_w_strb  = r_cmd ? w_strb : '0;
   assign mem_w_data  = r_cmd ? (r_wdata << w_shamt) : '0;

   // Command and write-data channels may complete in either order; the store finishes once both have.
   assign w_cmd_hs     = mem_valid && mem_ready;
   assign w_wr_hs      = mem_w_valid && mem_w_ready;
   assign w_store_done = (r_cmd_acc || w_cmd_hs) && (r_w_acc || w_wr_hs);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cmd       <= 1'b0;
         r_size      <= 2'd0;
         r_uns       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cmd_acc   <= 1'b0;
         r_w_acc     <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_cmd     <= req_cmd;
                  r_size    <= req_size;
                  r_uns     <= req_unsigned;
                  r_addr    <= req_addr;
                  r_wdata   <= req_wdata;
                  r_cmd_acc <= 1'b0;
                  r_w_acc   <= 1'b0;
                  if (w_req_illegal) begin
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                     r_state     <= ST_RESP;
                  end else begin
                     r_state <= ST_CMD;
                  end
               end
            end
            ST_CMD: begin
               if (r_cmd) begin
                  if (w_store_done) begin
                     r_rsp_err   <= 1'b0;
                     r_rsp_rdata <= '0;
                     r_state     <= ST_RESP;
                  end else begin
                     if (w_cmd_hs) r_cmd_acc <= 1'b1;
                     if (w_wr_hs)  r_w_acc   <= 1'b1;
                  end
               end else if (w_cmd_hs) begin
                  if (mem_r_valid) begin
                     r_rsp_err   <= 1'b0;
                     r_rsp_rdata <= w_load_ext;
                     r_state     <= ST_RESP;
                  end else begin
                     r_state <= ST_RDATA;
                  end
               end
            end
            ST_RDATA: begin
               if (mem_r_valid) begin
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= w_load_ext;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized and directed checks of dmem_lsu against a byte-level memory model.
// Revision 1.0
`default_nettype none

module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_cmd, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr;
   logic        mem_cmd;
   logic [1:0]  mem_size;
   logic        mem_valid, mem_ready, mem_r_valid, mem_r_ready;
   logic [31:0] mem_r_data;
   logic        mem_w_valid, mem_w_ready;
   logic [3:0]  mem_w_strb;
   logic [31:0] mem_w_data;

   int vectors = 0;
   int miscompares = 0;

   dmem_lsu dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_size(mem_size), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready),
      .mem_r_data(mem_r_data), .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
      .mem_w_strb(mem_w_strb), .mem_w_data(mem_w_data)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [64];
   logic [7:0]  ref_bytes [256];
   bit          wait_mode = 1'b0;
   bit          hold_r = 1'b0;
   int          stall_n = 0;
   bit          read_pending = 1'b0;
   logic [5:0]  pend_idx;
   int          cmd_hs, w_hs, r_hs;
   bit          mv_seen;
   logic [31:0] w_addr_o, w_data_o;
   logic [3:0]  w_strb_o;

   // Bus observer: counts handshakes and commits observed writes into the responder memory.
   always @(posedge clk) begin
      if (rst) begin
         if (mem_valid) mv_seen = 1'b1;
         if (mem_valid && mem_ready) begin
            cmd_hs++;
            if (!mem_cmd) begin
               if (mem_r_valid) r_hs++;
               else begin read_pending = 1'b1; pend_idx = mem_addr[7:2]; end
            end
         end else if (read_pending && mem_r_valid && mem_r_ready) begin
            read_pending = 1'b0;
            r_hs++;
         end
         if (mem_w_valid && mem_w_ready) begin
            w_hs++;
            w_addr_o = mem_addr; w_strb_o = mem_w_strb; w_data_o = mem_w_data;
            for (int i = 0; i < 4; i++)
               if (mem_w_strb[i]) mem[mem_addr[7:2]][8*i +: 8] = mem_w_data[8*i +: 8];
         end
      end
   end

   initial begin
      mem_ready = 1'b0; mem_w_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = '0;
      forever begin
         @(negedge clk);
         if (stall_n > 0 && (mem_valid || mem_w_valid)) begin
            mem_ready = 1'b0; mem_w_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = $urandom;
            stall_n--;
         end else begin
            mem_ready   = wait_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_w_ready = wait_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold_r) begin
               mem_r_valid = 1'b0; mem_r_data = $urandom;
            end else if (read_pending) begin
               mem_r_valid = wait_mode ? 1'($urandom_range(0, 1)) : 1'b1;
               mem_r_data  = mem[pend_idx];
            end else if (mem_valid && !mem_cmd && mem_ready && wait_mode) begin
               mem_r_valid = 1'($urandom_range(0, 1));
               mem_r_data  = mem[mem_addr[7:2]];
            end else begin
               // Stray r_valid with junk data before command acceptance must be ignored.
               mem_r_valid = wait_mode ? 1'($urandom_range(0, 1)) : 1'b0;
               mem_r_data  = $urandom;
            end
         end
      end
   end

   task automatic ref_access(input logic c, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er);
      int nb;
      logic [31:0] v;
      nb = 1 << sz;
      er = (sz == 2'd3) || ((a % nb) != 0);
      rd = '0;
      if (!er) begin
         if (c) begin
            for (int i = 0; i < nb; i++) ref_bytes[(a[7:0] + i) & 255] = wd[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[(a[7:0] + i) & 255]) << (8*i));
            if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rd = v;
         end
      end
   endtask

   task automatic do_txn(input logic c, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat, output logic mv1);
      int n;
      cmd_hs = 0; w_hs = 0; r_hs = 0; mv_seen = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_cmd = c; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      mv1 = mem_valid;
      lat = 1;
      while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
      if (!rsp_valid) lat = -1;
      rd = rsp_rdata; er = rsp_err;
   endtask

   task automatic test_reset();
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      vectors++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp got v=%b e=%b d=%h exp 0", rsp_valid, rsp_err, rsp_rdata); end
      vectors++; if (mem_valid !== 1'b0 || mem_w_valid !== 1'b0 || mem_r_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mem_hs got v=%b wv=%b rr=%b exp 0", mem_valid, mem_w_valid, mem_r_ready); end
      vectors++; if (mem_addr !== 32'h0 || mem_w_strb !== 4'h0 || mem_w_data !== 32'h0) begin miscompares++; $display("FAIL reset_mem_bus got a=%h s=%b d=%h exp 0", mem_addr, mem_w_strb, mem_w_data); end
   endtask

   task automatic test_directed();
      logic [31:0] rd, erd;
      logic er, eer, mv1;
      int lat;
      wait_mode = 1'b0;
      ref_access(1'b1, 2'd0, 1'b0, 32'h103, 32'hA5, erd, eer);
      do_txn(1'b1, 2'd0, 1'b0, 32'h103, 32'hA5, rd, er, lat, mv1);
      vectors++; if (lat !== 2 || mv1 !== 1'b1) begin miscompares++; $display("FAIL sb_latency got lat=%0d mv1=%b exp lat=2 mv1=1", lat, mv1); end
      vectors++; if (w_addr_o !== 32'h100 || w_strb_o !== 4'b1000 || w_data_o !== 32'hA500_0000) begin miscompares++; $display("FAIL sb_bus got a=%h s=%b d=%h exp 100 1000 a5000000", w_addr_o, w_strb_o, w_data_o); end
      vectors++; if (er !== 1'b0 || w_hs !== 1) begin miscompares++; $display("FAIL sb_rsp got err=%b writes=%0d exp 0 1", er, w_hs); end

      ref_access(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_7F01, erd, eer);
      do_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_7F01, rd, er, lat, mv1);
      vectors++; if (w_strb_o !== 4'b1111 || w_data_o !== 32'h80FF_7F01) begin miscompares++; $display("FAIL sw_bus got s=%b d=%h exp 1111 80ff7f01", w_strb_o, w_data_o); end

      do_txn(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, rd, er, lat, mv1);
      vectors++; if (rd !== 32'hFFFF_FFFF || er !== 1'b0 || lat !== 3) begin miscompares++; $display("FAIL lb_signed got d=%h e=%b lat=%0d exp ffffffff 0 3", rd, er, lat); end
      do_txn(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, rd, er, lat, mv1);
      vectors++; if (rd !== 32'h0000_00FF) begin miscompares++; $display("FAIL lbu got d=%h exp 000000ff", rd); end
      do_txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, rd, er, lat, mv1);
      vectors++; if (rd !== 32'hFFFF_80FF) begin miscompares++; $display("FAIL lh_signed got d=%h exp ffff80ff", rd); end
      do_txn(1'b0, 2'd2, 1'b1, 32'h100, 32'h0, rd, er, lat, mv1);
      vectors++; if (rd !== 32'h80FF_7F01) begin miscompares++; $display("FAIL lw got d=%h exp 80ff7f01", rd); end

      do_txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, rd, er, lat, mv1);
      vectors++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || mv_seen !== 1'b0) begin miscompares++; $display("FAIL misaligned got lat=%0d e=%b d=%h mv=%b exp 1 1 0 0", lat, er, rd, mv_seen); end
      rd = 32'h1;
      do_txn(1'b1, 2'd3, 1'b0, 32'h100, 32'h1234, rd, er, lat, mv1);
      vectors++; if (er !== 1'b1 || rd !== 32'h0 || mv_seen !== 1'b0 || w_hs !== 0) begin miscompares++; $display("FAIL size3 got e=%b d=%h mv=%b w=%0d exp 1 0 0 0", er, rd, mv_seen, w_hs); end
   endtask

   task automatic test_stall();
      logic [31:0] erd;
      logic eer;
      int n;
      wait_mode = 1'b0;
      ref_access(1'b1, 2'd1, 1'b0, 32'h104, 32'h0000_BEEF, erd, eer);
      cmd_hs = 0; w_hs = 0;
      stall_n = 3;
      @(negedge clk);
      req_valid = 1'b1; req_cmd = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
      req_addr = 32'h104; req_wdata = 32'h0000_BEEF;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         vectors++;
         if (mem_valid !== 1'b1 || mem_w_valid !== 1'b1 || mem_addr !== 32'h104 ||
             mem_w_strb !== 4'b0011 || mem_w_data !== 32'h0000_BEEF) begin
            miscompares++;
            $display("FAIL stall_hold cyc=%0d got v=%b wv=%b a=%h s=%b d=%h exp 1 1 104 0011 0000beef",
                     k, mem_valid, mem_w_valid, mem_addr, mem_w_strb, mem_w_data);
         end
      end
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || w_hs !== 1 || cmd_hs !== 1) begin miscompares++; $display("FAIL stall_done got rv=%b e=%b writes=%0d cmds=%0d exp 1 0 1 1", rsp_valid, rsp_err, w_hs, cmd_hs); end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, wd;
      logic er, eer, c, u, mv1;
      logic [1:0] sz;
      int lat;
      for (int t = 0; t < 200; t++) begin
         wait_mode = ($urandom_range(0, 3) != 0);
         c  = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         u  = 1'($urandom_range(0, 1));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~((2'd1 << sz) - 2'd1);
         wd = $urandom;
         ref_access(c, sz, u, a, wd, erd, eer);
         do_txn(c, sz, u, a, wd, rd, er, lat, mv1);
         vectors++;
         if (lat < 0 || er !== eer || rd !== erd) begin
            miscompares++;
            $display("FAIL rand_rsp t=%0d c=%b sz=%0d u=%b a=%h got d=%h e=%b lat=%0d exp d=%h e=%b",
                     t, c, sz, u, a, rd, er, lat, erd, eer);
         end
         vectors++;
         if (cmd_hs !== (eer ? 0 : 1) || w_hs !== ((c && !eer) ? 1 : 0) || (eer && mv_seen)) begin
            miscompares++;
            $display("FAIL rand_bus t=%0d got cmds=%0d writes=%0d mv=%b err=%b", t, cmd_hs, w_hs, mv_seen, eer);
         end
         if (c && !eer) begin
            vectors++;
            if (w_addr_o !== {a[31:2], 2'b00} ||
                w_strb_o !== 4'(((1 << (1 << sz)) - 1) << a[1:0]) ||
                w_data_o !== (wd << (8 * a[1:0]))) begin
               miscompares++;
               $display("FAIL rand_wr t=%0d got a=%h s=%b d=%h for a=%h sz=%0d wd=%h", t, w_addr_o, w_strb_o, w_data_o, a, sz, wd);
            end
         end
      end
      wait_mode = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd;
      logic er, eer, mv1;
      int lat, n;
      wait_mode = 1'b0;
      hold_r = 1'b1;
      cmd_hs = 0;
      @(negedge clk);
      req_valid = 1'b1; req_cmd = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (cmd_hs == 0 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      vectors++; if (mem_r_ready !== 1'b1 || mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rdata_wait got rr=%b v=%b rv=%b exp 1 0 0", mem_r_ready, mem_valid, rsp_valid); end
      rst = 1'b0;
      #1;
      vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_r_ready !== 1'b0 || mem_valid !== 1'b0) begin miscompares++; $display("FAIL midreset got rdy=%b rv=%b rr=%b v=%b exp 1 0 0 0", req_ready, rsp_valid, mem_r_ready, mem_valid); end
      @(negedge clk);
      read_pending = 1'b0;
      hold_r = 1'b0;
      rst = 1'b1;
      ref_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, erd, eer);
      do_txn(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, rd, er, lat, mv1);
      vectors++; if (rd !== erd || er !== 1'b0 || lat !== 3) begin miscompares++; $display("FAIL post_reset_load got d=%h e=%b lat=%0d exp %h 0 3", rd, er, lat, erd); end
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_cmd = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = mem[i][8*b +: 8];
      end
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b1;
      test_directed();
      test_stall();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
